bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock, for score, coin and timer display paths. It replaces the fully combinational converter wherever BIN_BITS is large enough that the unrolled add-3 array costs too much area or timing. It adds a valid/ready handshake on both sides, optional two's-complement input, overflow detection when DIGITS is too small, and a significant-digit count for leading-zero blanking.

## Interface
- BIN_BITS, default 32: binary input width, ≥4.
- DIGITS, default 10: BCD digits produced; output width is 4*DIGITS.
- CW, derived as ceil(log2(DIGITS+1)) by a constant function; not overridable.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request carries a value to convert.
- in_ready  out  1  converter can accept a request.
- bin  in  BIN_BITS  value; sampled on accept.
- sign_mode  in  1  1 = treat bin as two's complement; sampled on accept.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes the result.
- bcd  out  4*DIGITS  magnitude, digit 0 in bits [3:0].
- neg  out  1  input was negative (sign_mode=1 and bin MSB=1).
- overflow  out  1  magnitude ≥ 10^DIGITS; bcd holds magnitude mod 10^DIGITS.
- digit_count  out  CW  significant digits in bcd; 1 for zero.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid, capture mag = (sign_mode && bin[MSB]) ? -bin : bin as a BIN_BITS unsigned value (-2^(BIN_BITS-1) maps to 2^(BIN_BITS-1)). Capture neg, clear the BCD register and the overflow flag, load bit counter = BIN_BITS, then go to SHIFT.
- SHIFT: each cycle, every digit ≥5 gets +3. The BCD register then shifts left by one, taking the MSB of mag, and mag shifts left. The bit shifted out of the top digit is ORed into the sticky overflow. The counter decrements. When the counter reaches 0, go to DONE.
- DONE: out_valid=1. bcd, neg, overflow and digit_count stay stable. On out_ready, go to IDLE.
- in_ready is 1 only in IDLE. in_valid in SHIFT or DONE is ignored and not queued.
- digit_count is combinational from the result register: index of the highest nonzero digit plus 1, or 1 if all digits are zero. It is meaningful only while out_valid=1.
- Reset at any point, including mid-SHIFT, aborts the conversion. The aborted result is never presented.
- Reset values: in_ready=1, out_valid=0, bcd=0, neg=0, overflow=0, digit_count=1.

## Timing
- Accept happens on a clock edge with in_valid && in_ready.
- out_valid rises exactly BIN_BITS edges after the accepting edge, independent of the value.
- The result holds indefinitely under out_ready=0.
- The handshake edge with out_valid && out_ready returns the block to IDLE. in_ready=1 on the following cycle.
- The earliest next accept is one edge after the result handshake. Minimum period is BIN_BITS+2 cycles per conversion.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- A shared package or header holds the FSM state encodings (2-bit), the add-3 function (input ≥5 gives +3, otherwise unchanged), and the constant ceil-log2 function.
- One natural sub-module, bcd_digit_add3: a combinational 4-bit digit cell, instantiated DIGITS times in a generate loop.
- The top level holds the FSM, the counter, the mag/BCD shift registers and the digit_count priority encoder.

## Test plan
- Default parameters, sign_mode=0, bin=0xFFFFFFFF -> out_valid 32 edges after accept; bcd=0x4294967295, digit_count=10, overflow=0, neg=0.
- sign_mode=1, bin=0x80000000 -> neg=1, bcd=0x2147483648, overflow=0. Also sign_mode=1, bin=0xFFFFFFFF -> neg=1, bcd=1, digit_count=1.
- bin=0 -> bcd=0, digit_count=1, neg=0, overflow=0.
- BIN_BITS=10, DIGITS=3, bin=1023 -> overflow=1, bcd=0x023, digit_count=2. With bin=999 -> overflow=0, bcd=0x999.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and bin -> outputs stable, in_ready=0, nothing captured. Then out_ready=1 -> in_ready=1 on the next cycle, and a new value converts correctly.
- Assert rst for 1 cycle mid-SHIFT -> next cycle shows all outputs at reset values. No out_valid appears for the aborted conversion, and a following conversion is correct.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: FSM encodings and helper functions shared by the converter
package bin_to_bcd_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction
  function automatic int ceil_log2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v >>= 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: request/result handshake bundle for the sequential converter
interface bin_to_bcd_seq_if #(parameter int BIN_BITS = 32, parameter int DIGITS = 10);
  import bin_to_bcd_seq_pkg::*;
  localparam int CW = ceil_log2(DIGITS + 1);
  logic in_valid;
  logic in_ready;
  logic [BIN_BITS-1:0] bin;
  logic sign_mode;
  logic out_valid;
  logic out_ready;
  logic [4*DIGITS-1:0] bcd;
  logic neg;
  logic overflow;
  logic [CW-1:0] digit_count;
  modport master (output in_valid, bin, sign_mode, out_ready,
                  input in_ready, out_valid, bcd, neg, overflow, digit_count);
  modport slave (input in_valid, bin, sign_mode, out_ready,
                 output in_ready, out_valid, bcd, neg, overflow, digit_count);
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_digit_add3: one BCD digit pre-shift correction cell
module bcd_digit_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = add3(d);
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock double-dabble converter with handshakes and overflow
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_BITS = 32,
  parameter int DIGITS = 10
) (
  input logic clk,
  input logic rst,
  bin_to_bcd_seq_if.slave io
);
  localparam int CW = ceil_log2(DIGITS + 1);
  localparam int KW = ceil_log2(BIN_BITS + 1);
  state_t state;
  logic [BIN_BITS-1:0] mag;
  logic [KW-1:0] cnt;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS:0] sh;
  logic [CW-1:0] dc;
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_add3 u_add3 (.d(bcd_r[4*g +: 4]), .q(adj[4*g +: 4]));
    end
  endgenerate
  // top bit of sh is the carry leaving the highest digit, i.e. a wrap past 10^DIGITS
  assign sh = {adj, mag[BIN_BITS-1]};
  always_comb begin
    dc = CW'(1);
    for (int i = 0; i < DIGITS; i++) dc = (bcd_r[4*i +: 4] != 4'd0) ? CW'(i + 1) : dc;
  end
  assign io.bcd = bcd_r;
  assign io.digit_count = dc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      io.in_ready <= 1'b1;
      io.out_valid <= 1'b0;
      io.neg <= 1'b0;
      io.overflow <= 1'b0;
      bcd_r <= '0;
      mag <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          mag <= (io.sign_mode && io.bin[BIN_BITS-1]) ? -io.bin : io.bin;
          io.neg <= io.sign_mode && io.bin[BIN_BITS-1];
          io.overflow <= 1'b0;
          bcd_r <= '0;
          cnt <= KW'(BIN_BITS);
          io.in_ready <= 1'b0;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd_r <= sh[4*DIGITS-1:0];
          io.overflow <= io.overflow | sh[4*DIGITS];
          mag <= mag << 1;
          cnt <= cnt - KW'(1);
          if (cnt == KW'(1)) begin
            io.out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (io.out_ready) begin
          io.out_valid <= 1'b0;
          io.in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized and directed checks of two converter configurations against an arithmetic model
module tb_bin_to_bcd_seq;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bin_to_bcd_seq_if #(.BIN_BITS(32), .DIGITS(10)) a ();
  bin_to_bcd_seq_if #(.BIN_BITS(10), .DIGITS(3)) b ();
  bin_to_bcd_seq #(.BIN_BITS(32), .DIGITS(10)) dut_a (.clk(clk), .rst(rst), .io(a.slave));
  bin_to_bcd_seq #(.BIN_BITS(10), .DIGITS(3)) dut_b (.clk(clk), .rst(rst), .io(b.slave));

  task automatic model(input logic [63:0] v, input int bits, input bit sm, input int digits,
                       output logic [39:0] bcd, output bit neg, output bit ovf, output int dc);
    longint unsigned full, ub, m, lim, r;
    full = 64'd1 << bits;
    ub = v & (full - 1);
    neg = sm && ub >= (full >> 1);
    m = neg ? full - ub : ub;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ovf = m >= lim;
    r = m % lim;
    bcd = '0;
    dc = 1;
    for (int i = 0; i < digits; i++) begin
      bcd[4*i +: 4] = 4'(r % 10);
      if (r % 10 != 0) dc = i + 1;
      r = r / 10;
    end
  endtask

  task automatic run_a(input logic [31:0] v, input bit sm, output int lat, output logic [39:0] bcd,
                       output bit neg, output bit ovf, output int dc);
    for (int k = 0; k < 200 && !a.in_ready; k++) begin @(posedge clk); #1; end
    a.in_valid = 1; a.bin = v; a.sign_mode = sm;
    @(posedge clk); #1;
    a.in_valid = 0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (a.out_valid) begin lat = k - 1; break; end
      @(posedge clk); #1;
    end
    if (a.out_valid && lat < 0) lat = 100;
    bcd = a.bcd; neg = a.neg; ovf = a.overflow; dc = int'(a.digit_count);
    a.out_ready = 1;
    @(posedge clk); #1;
    a.out_ready = 0;
  endtask

  task automatic run_b(input logic [9:0] v, input bit sm, output int lat, output logic [39:0] bcd,
                       output bit neg, output bit ovf, output int dc);
    for (int k = 0; k < 200 && !b.in_ready; k++) begin @(posedge clk); #1; end
    b.in_valid = 1; b.bin = v; b.sign_mode = sm;
    @(posedge clk); #1;
    b.in_valid = 0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (b.out_valid) begin lat = k - 1; break; end
      @(posedge clk); #1;
    end
    bcd = {28'd0, b.bcd}; neg = b.neg; ovf = b.overflow; dc = int'(b.digit_count);
    b.out_ready = 1;
    @(posedge clk); #1;
    b.out_ready = 0;
  endtask

  task automatic check_conv(input string name, input bit is_a, input logic [31:0] v, input bit sm);
    int lat, dc, edc;
    logic [39:0] bcd, ebcd;
    bit neg, ovf, eneg, eovf;
    if (is_a) run_a(v, sm, lat, bcd, neg, ovf, dc);
    else run_b(v[9:0], sm, lat, bcd, neg, ovf, dc);
    model({32'd0, v}, is_a ? 32 : 10, sm, is_a ? 10 : 3, ebcd, eneg, eovf, edc);
    checks++;
    if (lat !== (is_a ? 32 : 10)) begin
      errors++;
      $display("FAIL %s latency bin=%h: got %0d want %0d", name, v, lat, is_a ? 32 : 10);
    end
    checks++;
    if ({bcd, neg, ovf} !== {ebcd, eneg, eovf} || dc != edc) begin
      errors++;
      $display("FAIL %s result bin=%h sm=%0d: got bcd=%h neg=%0d ovf=%0d dc=%0d want bcd=%h neg=%0d ovf=%0d dc=%0d",
               name, v, sm, bcd, neg, ovf, dc, ebcd, eneg, eovf, edc);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a.in_ready, a.out_valid, a.bcd, a.neg, a.overflow, a.digit_count} !== {1'b1, 1'b0, 40'd0, 1'b0, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL reset_a: got rdy=%0d vld=%0d bcd=%h neg=%0d ovf=%0d dc=%0d want 1 0 0 0 0 1",
               a.in_ready, a.out_valid, a.bcd, a.neg, a.overflow, a.digit_count);
    end
    checks++;
    if ({b.in_ready, b.out_valid, b.bcd, b.neg, b.overflow, b.digit_count} !== {1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL reset_b: got rdy=%0d vld=%0d bcd=%h neg=%0d ovf=%0d dc=%0d want 1 0 0 0 0 1",
               b.in_ready, b.out_valid, b.bcd, b.neg, b.overflow, b.digit_count);
    end
    rst = 0;
  endtask

  task automatic test_directed();
    int lat, dc;
    logic [39:0] bcd;
    bit neg, ovf;
    check_conv("max_unsigned", 1, 32'hFFFF_FFFF, 0);
    check_conv("min_signed", 1, 32'h8000_0000, 1);
    check_conv("minus_one", 1, 32'hFFFF_FFFF, 1);
    check_conv("zero", 1, 32'd0, 0);
    check_conv("small_ovf", 0, 32'd1023, 0);
    check_conv("small_999", 0, 32'd999, 0);
    check_conv("small_neg512", 0, 32'h200, 1);
    run_b(10'd1023, 0, lat, bcd, neg, ovf, dc);
    checks++;
    if ({ovf, bcd[11:0], dc} !== {1'b1, 12'h023, 32'd2}) begin
      errors++;
      $display("FAIL const_1023: got ovf=%0d bcd=%h dc=%0d want ovf=1 bcd=023 dc=2", ovf, bcd[11:0], dc);
    end
    run_a(32'hFFFF_FFFF, 0, lat, bcd, neg, ovf, dc);
    checks++;
    if ({ovf, neg, bcd, dc} !== {1'b0, 1'b0, 40'h42_9496_7295, 32'd10}) begin
      errors++;
      $display("FAIL const_max: got ovf=%0d neg=%0d bcd=%h dc=%0d want 0 0 4294967295 10", ovf, neg, bcd, dc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) check_conv("rand_a", 1, $urandom >> $urandom_range(0, 31), 1'($urandom));
    for (int i = 0; i < 20; i++) check_conv("rand_b", 0, 32'($urandom_range(0, 1023)), 1'($urandom));
  endtask

  task automatic test_hold();
    logic [39:0] hb;
    bit hn, ho;
    logic [3:0] hd;
    logic [31:0] v;
    v = $urandom;
    a.in_valid = 1; a.bin = v; a.sign_mode = 0;
    @(posedge clk); #1;
    a.in_valid = 0;
    for (int k = 0; k < 50 && !a.out_valid; k++) begin @(posedge clk); #1; end
    hb = a.bcd; hn = a.neg; ho = a.overflow; hd = a.digit_count;
    for (int k = 0; k < 5; k++) begin
      a.in_valid = ~a.in_valid; a.bin = $urandom; a.sign_mode = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({a.out_valid, a.in_ready, a.bcd, a.neg, a.overflow, a.digit_count} !== {1'b1, 1'b0, hb, hn, ho, hd}) begin
        errors++;
        $display("FAIL hold cycle %0d: got vld=%0d rdy=%0d bcd=%h want vld=1 rdy=0 bcd=%h", k,
                 a.out_valid, a.in_ready, a.bcd, hb);
      end
    end
    a.in_valid = 0; a.out_ready = 1;
    @(posedge clk); #1;
    a.out_ready = 0;
    checks++;
    if ({a.in_ready, a.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL hold_release: got rdy=%0d vld=%0d want rdy=1 vld=0", a.in_ready, a.out_valid);
    end
    check_conv("after_hold", 1, $urandom, 0);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    a.in_valid = 1; a.bin = 32'd123456789; a.sign_mode = 0;
    @(posedge clk); #1;
    a.in_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if ({a.in_ready, a.out_valid, a.bcd, a.neg, a.overflow, a.digit_count} !== {1'b1, 1'b0, 40'd0, 1'b0, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%0d vld=%0d bcd=%h neg=%0d ovf=%0d dc=%0d want 1 0 0 0 0 1",
               a.in_ready, a.out_valid, a.bcd, a.neg, a.overflow, a.digit_count);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (a.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted_result: got %0d valid cycles want 0", seen);
    end
    check_conv("after_abort", 1, 32'hDEAD_BEEF, 1);
  endtask

  task automatic test_back_to_back();
    int t0 = -1, t1 = -1;
    b.in_valid = 1; b.bin = 10'd777; b.sign_mode = 0; b.out_ready = 1;
    for (int k = 0; k < 60 && t1 < 0; k++) begin
      @(posedge clk); #1;
      if (b.out_valid) begin
        if (t0 < 0) t0 = k; else t1 = k;
        checks++;
        if ({b.bcd, b.overflow} !== {12'h777, 1'b0}) begin
          errors++;
          $display("FAIL b2b_result: got bcd=%h ovf=%0d want 777 0", b.bcd, b.overflow);
        end
      end
    end
    b.in_valid = 0;
    @(posedge clk); #1;
    b.out_ready = 0;
    checks++;
    if (t1 - t0 != 12 || t0 < 0) begin
      errors++;
      $display("FAIL b2b_period: got %0d want 12", t1 - t0);
    end
  endtask

  initial begin
    a.in_valid = 0; a.bin = 0; a.sign_mode = 0; a.out_ready = 0;
    b.in_valid = 0; b.bin = 0; b.sign_mode = 0; b.out_ready = 0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
